// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, reads instruction words over a
// request/response handshake with at most one outstanding, and presents each
// word with its PC to decode. Back-pressure comes from Stall. Redirect discards
// wrong-path fetches.
// Optional feature macro: FETCH_PREFETCH_EN. When it is defined, the unit
// fetches the next sequential word while decode is stalled, into a one-entry
// buffer.
`timescale 1ns/1ps

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] Instruction,
  output logic [5:0]  OP,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PC_4
);

  typedef enum logic [1:0] {StFetch, StWait, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        req_raw;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc_inc;

`ifdef FETCH_PREFETCH_EN
  logic        buf_full_q, buf_full_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  // A prefetch request was accepted in HOLD and its response is still due.
  logic        pf_pend_q, pf_pend_d;
`endif

  // Low address bits of the redirect target are forced to word alignment.
  assign redirect_pc  = RedirectPC & 32'hFFFF_FFFC;
  assign fetch_pc_inc = fetch_pc_q + 32'd4;

  // Request is gated by reset; the address is only driven alongside a request.
  assign IMemReq     = reset & req_raw;
  assign IMemAddr    = IMemReq ? fetch_pc_q : 32'h0;
  assign Instruction = instr_q;
  assign OP          = instr_q[31:26];
  assign InstrValid  = valid_q;
  assign PC          = pc_q;
  assign PC_4        = pc4_q;

  // Next-state logic for the fetch FSM and the presented-instruction registers.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    req_raw    = 1'b0;
`ifdef FETCH_PREFETCH_EN
    buf_full_d  = buf_full_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    pf_pend_d   = pf_pend_q;
`endif

    unique case (state_q)
      StFetch: begin
        req_raw = 1'b1;
        if (Redirect) begin
          fetch_pc_d = redirect_pc;
          // The accepted request belongs to the old path; its response is dropped.
          if (IMemAck) state_d = StDrop;
        end else if (IMemAck) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (IMemRValid && Redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = StFetch;
        end else if (IMemRValid) begin
          instr_d    = IMemRData;
          pc_d       = fetch_pc_q;
          pc4_d      = fetch_pc_inc;
          valid_d    = 1'b1;
          fetch_pc_d = fetch_pc_inc;
          state_d    = StHold;
        end else if (Redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = StDrop;
        end
      end

      StHold: begin
`ifdef FETCH_PREFETCH_EN
        req_raw = !buf_full_q && !pf_pend_q;
`endif
        if (Redirect) begin
          // Redirect wins over a simultaneous transfer.
          valid_d    = 1'b0;
          fetch_pc_d = redirect_pc;
          state_d    = StFetch;
`ifdef FETCH_PREFETCH_EN
          buf_full_d = 1'b0;
          pf_pend_d  = 1'b0;
          if ((pf_pend_q && !IMemRValid) || (req_raw && IMemAck)) state_d = StDrop;
`endif
        end else if (!Stall) begin
`ifdef FETCH_PREFETCH_EN
          if (buf_full_q) begin
            instr_d    = buf_instr_q;
            pc_d       = buf_pc_q;
            pc4_d      = buf_pc_q + 32'd4;
            buf_full_d = 1'b0;
          end else if (pf_pend_q && IMemRValid) begin
            // Prefetch data lands straight on the outputs: no bubble.
            instr_d    = IMemRData;
            pc_d       = fetch_pc_q;
            pc4_d      = fetch_pc_inc;
            fetch_pc_d = fetch_pc_inc;
            pf_pend_d  = 1'b0;
          end else if (pf_pend_q || (req_raw && IMemAck)) begin
            valid_d   = 1'b0;
            pf_pend_d = 1'b0;
            state_d   = StWait;
          end else begin
            valid_d = 1'b0;
            state_d = StFetch;
          end
`else
          valid_d = 1'b0;
          state_d = StFetch;
`endif
        end
`ifdef FETCH_PREFETCH_EN
        else if (pf_pend_q && IMemRValid) begin
          buf_full_d  = 1'b1;
          buf_instr_d = IMemRData;
          buf_pc_d    = fetch_pc_q;
          fetch_pc_d  = fetch_pc_inc;
          pf_pend_d   = 1'b0;
        end else if (req_raw && IMemAck) begin
          pf_pend_d = 1'b1;
        end
`endif
      end

      StDrop: begin
        if (Redirect) fetch_pc_d = redirect_pc;
        if (IMemRValid) state_d = StFetch;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_VECTOR;
      instr_q    <= 32'h0;
      pc_q       <= 32'h0;
      pc4_q      <= 32'd4;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
    end
  end

`ifdef FETCH_PREFETCH_EN
  // Prefetch buffer and outstanding-prefetch tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_full_q  <= 1'b0;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
      pf_pend_q   <= 1'b0;
    end else begin
      buf_full_q  <= buf_full_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      pf_pend_q   <= pf_pend_d;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run against an instruction-stream model (next expected PC) and a
// word-per-address memory model.
`timescale 1ns/1ps

module tb_instruction_fetch_unit;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic        IMemRValid;
  logic [31:0] IMemRData;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] Instruction;
  logic [5:0]  OP;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PC_4;

  int checks = 0;
  int errors = 0;

  // Memory model configuration and state.
  bit          mem_rand = 1'b0;
  int          fix_resp = 1;
  bit          pend = 1'b0;
  logic [31:0] resp_addr = 32'h0;
  int          resp_wait = 0;
  int          ack_wait = 0;

  instruction_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemAck    (IMemAck),
    .IMemRValid (IMemRValid),
    .IMemRData  (IMemRData),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Instruction(Instruction),
    .OP         (OP),
    .InstrValid (InstrValid),
    .PC         (PC),
    .PC_4       (PC_4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Instruction memory: acks a request after 0..2 cycles, answers 1..3 cycles later.
  initial begin
    IMemAck    = 1'b0;
    IMemRValid = 1'b0;
    IMemRData  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        IMemAck    = 1'b0;
        IMemRValid = 1'b0;
        pend       = 1'b0;
        ack_wait   = 0;
      end else begin
        IMemRValid = 1'b0;
        if (pend) begin
          if (resp_wait <= 1) begin
            IMemRValid = 1'b1;
            IMemRData  = mem_word(resp_addr);
            pend       = 1'b0;
          end else begin
            resp_wait--;
          end
        end
        IMemAck = 1'b0;
        if (IMemReq && !pend && !IMemRValid) begin
          if (ack_wait == 0) IMemAck = 1'b1;
          else ack_wait--;
        end
      end
      @(negedge clk);
      if (reset && IMemReq && IMemAck) begin
        pend      = 1'b1;
        resp_addr = IMemAddr;
        resp_wait = mem_rand ? int'($urandom_range(1, 3)) : fix_resp;
        ack_wait  = mem_rand ? int'($urandom_range(0, 2)) : 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 of cycle 0, the first cycle out of reset.
  task automatic do_reset();
    reset    = 1'b0;
    Redirect = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    cyc();
    cyc();
    @(negedge clk);
    checks++; if (IMemReq !== 1'b0) begin errors++;
      $display("FAIL reset_req got %b want 0", IMemReq); end
    checks++; if (IMemAddr !== 32'h0) begin errors++;
      $display("FAIL reset_addr got %h want 0", IMemAddr); end
    checks++; if (InstrValid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got %b want 0", InstrValid); end
    checks++; if (Instruction !== 32'h0 || OP !== 6'h0) begin errors++;
      $display("FAIL reset_instr got %h/%h want 0/0", Instruction, OP); end
    checks++; if (PC !== 32'h0 || PC_4 !== 32'h4) begin errors++;
      $display("FAIL reset_pc got %h/%h want 0/4", PC, PC_4); end
  endtask

  task automatic test_first_fetch();
    mem_rand = 1'b0;
    fix_resp = 1;
    Stall    = 1'b0;
    do_reset();
    @(negedge clk);
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== RV) begin errors++;
      $display("FAIL first_req got %b/%h want 1/%h", IMemReq, IMemAddr, RV); end
    cyc();
    @(negedge clk);
    checks++; if (InstrValid !== 1'b0) begin errors++;
      $display("FAIL first_early_valid got %b want 0", InstrValid); end
    cyc();
    @(negedge clk);
    checks++; if (InstrValid !== 1'b1) begin errors++;
      $display("FAIL first_valid got %b want 1", InstrValid); end
    checks++; if (OP !== 6'h08 || Instruction !== 32'h2008_0005) begin errors++;
      $display("FAIL first_op got %h/%h want 08/20080005", OP, Instruction); end
    checks++; if (PC !== RV || PC_4 !== RV + 32'd4) begin errors++;
      $display("FAIL first_pc got %h/%h want %h/%h", PC, PC_4, RV, RV + 32'd4); end
  endtask

  task automatic test_stall();
    bit          seen = 1'b0;
    bit          got_req = 1'b0;
    logic [31:0] req_addr = 32'h0;
    mem_rand = 1'b0;
    fix_resp = 1;
    Stall    = 1'b1;
    do_reset();
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (InstrValid) seen = 1'b1;
      else cyc();
    end
    checks++; if (!seen) begin errors++;
      $display("FAIL stall_first_valid got 0 want 1 within 10 cycles"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        cyc();
        @(negedge clk);
      end
      checks++; if (InstrValid !== 1'b1 || PC !== RV || Instruction !== mem_word(RV)) begin
        errors++;
        $display("FAIL stall_hold got %b/%h/%h want 1/%h/%h", InstrValid, PC, Instruction, RV,
                 mem_word(RV));
      end
`ifndef FETCH_PREFETCH_EN
      checks++; if (IMemReq !== 1'b0) begin errors++;
        $display("FAIL stall_no_req got %b want 0", IMemReq); end
`endif
      if (IMemReq && !got_req) begin got_req = 1'b1; req_addr = IMemAddr; end
    end
    cyc();
    Stall = 1'b0;
    @(negedge clk);
    checks++; if (InstrValid !== 1'b1 || PC !== RV) begin errors++;
      $display("FAIL stall_transfer got %b/%h want 1/%h", InstrValid, PC, RV); end
    if (IMemReq && !got_req) begin got_req = 1'b1; req_addr = IMemAddr; end
    cyc();
    Stall = 1'b1;
    @(negedge clk);
    checks++; if (InstrValid === 1'b1 && PC === RV) begin errors++;
      $display("FAIL stall_double_transfer got PC %h again want a single transfer", PC); end
    if (IMemReq && !got_req) begin got_req = 1'b1; req_addr = IMemAddr; end
    for (int i = 0; i < 10 && !got_req; i++) begin
      cyc();
      @(negedge clk);
      if (IMemReq) begin got_req = 1'b1; req_addr = IMemAddr; end
    end
    checks++; if (!got_req || req_addr !== RV + 32'd4) begin errors++;
      $display("FAIL stall_next_addr got %b/%h want 1/%h", got_req, req_addr, RV + 32'd4); end
    Stall = 1'b0;
  endtask

  task automatic test_redirect_wait();
    bit          saw_valid = 1'b0;
    bit          got_req = 1'b0;
    bit          seen = 1'b0;
    logic [31:0] req_addr = 32'h0;
    mem_rand = 1'b0;
    fix_resp = 3;
    Stall    = 1'b0;
    do_reset();
    cyc();
    Redirect   = 1'b1;
    RedirectPC = 32'h0040_0103;
    @(negedge clk);
    checks++; if (IMemReq !== 1'b0) begin errors++;
      $display("FAIL rdw_wait_req got %b want 0", IMemReq); end
    cyc();
    Redirect   = 1'b0;
    RedirectPC = 32'hDEAD_BEEF;
    for (int i = 0; i < 10 && !got_req; i++) begin
      @(negedge clk);
      if (InstrValid) saw_valid = 1'b1;
      if (IMemReq) begin got_req = 1'b1; req_addr = IMemAddr; end
      else cyc();
    end
    checks++; if (saw_valid) begin errors++;
      $display("FAIL rdw_stale_valid got 1 want 0"); end
    checks++; if (!got_req || req_addr !== 32'h0040_0100) begin errors++;
      $display("FAIL rdw_next_addr got %b/%h want 1/00400100", got_req, req_addr); end
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc();
      @(negedge clk);
      if (InstrValid) seen = 1'b1;
    end
    checks++; if (!seen || PC !== 32'h0040_0100 || Instruction !== mem_word(32'h0040_0100))
    begin
      errors++;
      $display("FAIL rdw_new_path got %b/%h/%h want 1/00400100/%h", seen, PC, Instruction,
               mem_word(32'h0040_0100));
    end
  endtask

  task automatic test_redirect_rvalid();
    bit          saw_valid = 1'b0;
    bit          got_req = 1'b0;
    bit          seen = 1'b0;
    logic [31:0] req_addr = 32'h0;
    mem_rand = 1'b0;
    fix_resp = 1;
    Stall    = 1'b0;
    do_reset();
    cyc();
    Redirect   = 1'b1;
    RedirectPC = 32'h0040_1002;
    cyc();
    Redirect   = 1'b0;
    for (int i = 0; i < 10 && !got_req; i++) begin
      @(negedge clk);
      if (InstrValid) saw_valid = 1'b1;
      if (IMemReq) begin got_req = 1'b1; req_addr = IMemAddr; end
      else cyc();
    end
    checks++; if (saw_valid) begin errors++;
      $display("FAIL rdr_stale_valid got 1 want 0"); end
    checks++; if (!got_req || req_addr !== 32'h0040_1000) begin errors++;
      $display("FAIL rdr_next_addr got %b/%h want 1/00401000", got_req, req_addr); end
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc();
      @(negedge clk);
      if (InstrValid) seen = 1'b1;
    end
    checks++; if (!seen || PC !== 32'h0040_1000 || PC_4 !== 32'h0040_1004) begin errors++;
      $display("FAIL rdr_new_path got %b/%h/%h want 1/00401000/00401004", seen, PC, PC_4); end
  endtask

  task automatic test_redirect_hold();
    bit          saw_valid = 1'b0;
    bit          got_req = 1'b0;
    bit          seen = 1'b0;
    logic [31:0] req_addr = 32'h0;
    mem_rand = 1'b0;
    fix_resp = 1;
    Stall    = 1'b0;
    do_reset();
    cyc();
    cyc();
    Redirect   = 1'b1;
    RedirectPC = 32'h0040_2008;
    @(negedge clk);
    checks++; if (InstrValid !== 1'b1 || PC !== RV) begin errors++;
      $display("FAIL rdh_present got %b/%h want 1/%h", InstrValid, PC, RV); end
    cyc();
    Redirect = 1'b0;
    for (int i = 0; i < 10 && !got_req; i++) begin
      @(negedge clk);
      if (InstrValid) saw_valid = 1'b1;
      if (IMemReq) begin got_req = 1'b1; req_addr = IMemAddr; end
      else cyc();
    end
    checks++; if (saw_valid) begin errors++;
      $display("FAIL rdh_stale_valid got 1 want 0"); end
    checks++; if (!got_req || req_addr !== 32'h0040_2008) begin errors++;
      $display("FAIL rdh_next_addr got %b/%h want 1/00402008", got_req, req_addr); end
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc();
      @(negedge clk);
      if (InstrValid) seen = 1'b1;
    end
    checks++; if (!seen || PC !== 32'h0040_2008) begin errors++;
      $display("FAIL rdh_new_path got %b/%h want 1/00402008", seen, PC); end
  endtask

  task automatic test_reset_hold_wrap();
    bit          seen = 1'b0;
    bit          got_req = 1'b0;
    logic [31:0] req_addr = 32'h0;
    mem_rand = 1'b0;
    fix_resp = 1;
    Stall    = 1'b1;
    do_reset();
    cyc();
    cyc();
    @(negedge clk);
    checks++; if (InstrValid !== 1'b1) begin errors++;
      $display("FAIL rsth_valid got %b want 1", InstrValid); end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (IMemReq !== 1'b0) begin errors++;
      $display("FAIL rsth_req_gate got %b want 0", IMemReq); end
    cyc();
    @(negedge clk);
    checks++; if (IMemReq !== 1'b0 || IMemAddr !== 32'h0 || InstrValid !== 1'b0) begin errors++;
      $display("FAIL rsth_ctrl got %b/%h/%b want 0/0/0", IMemReq, IMemAddr, InstrValid); end
    checks++; if (Instruction !== 32'h0 || OP !== 6'h0 || PC !== 32'h0 || PC_4 !== 32'h4)
    begin
      errors++;
      $display("FAIL rsth_data got %h/%h/%h/%h want 0/0/0/4", Instruction, OP, PC, PC_4);
    end
    cyc();
    reset = 1'b1;
    Stall = 1'b0;
    @(negedge clk);
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== RV) begin errors++;
      $display("FAIL rsth_restart got %b/%h want 1/%h", IMemReq, IMemAddr, RV); end
    cyc();
    cyc();
    Redirect   = 1'b1;
    RedirectPC = 32'hFFFF_FFFC;
    cyc();
    Redirect = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (InstrValid) seen = 1'b1;
      else cyc();
    end
    checks++; if (!seen || PC !== 32'hFFFF_FFFC || PC_4 !== 32'h0) begin errors++;
      $display("FAIL wrap_pc got %b/%h/%h want 1/fffffffc/0", seen, PC, PC_4); end
    checks++; if (Instruction !== mem_word(32'hFFFF_FFFC)) begin errors++;
      $display("FAIL wrap_instr got %h want %h", Instruction, mem_word(32'hFFFF_FFFC)); end
    for (int i = 0; i < 10 && !got_req; i++) begin
      if (i > 0) begin
        cyc();
        @(negedge clk);
      end
      if (IMemReq) begin got_req = 1'b1; req_addr = IMemAddr; end
    end
    checks++; if (!got_req || req_addr !== 32'h0) begin errors++;
      $display("FAIL wrap_next_addr got %b/%h want 1/0", got_req, req_addr); end
  endtask

`ifdef FETCH_PREFETCH_EN
  task automatic test_prefetch();
    int n_req = 0;
    mem_rand = 1'b0;
    fix_resp = 1;
    Stall    = 1'b1;
    do_reset();
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (IMemReq) n_req++;
      cyc();
    end
    Stall = 1'b0;
    @(negedge clk);
    if (IMemReq) n_req++;
    checks++; if (InstrValid !== 1'b1 || PC !== RV) begin errors++;
      $display("FAIL pf_transfer got %b/%h want 1/%h", InstrValid, PC, RV); end
    checks++; if (n_req != 1) begin errors++;
      $display("FAIL pf_req_count got %0d want 1", n_req); end
    cyc();
    Stall = 1'b1;
    @(negedge clk);
    checks++; if (InstrValid !== 1'b1 || PC !== RV + 32'd4) begin errors++;
      $display("FAIL pf_no_bubble got %b/%h want 1/%h", InstrValid, PC, RV + 32'd4); end
    checks++; if (Instruction !== mem_word(RV + 32'd4)) begin errors++;
      $display("FAIL pf_instr got %h want %h", Instruction, mem_word(RV + 32'd4)); end
    Stall = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [31:0] exp_pc = RV;
    logic [31:0] exp_w;
    logic [31:0] tmp;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    bit          prev_redir = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          n_xfer = 0;
    mem_rand = 1'b1;
    Stall    = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      Stall    = ($urandom_range(0, 99) < 30);
      Redirect = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 2))
        0: RedirectPC = $urandom;
        1: begin tmp = $urandom_range(0, 15); RedirectPC = 32'hFFFF_FFF0 | tmp; end
        default: begin tmp = $urandom_range(0, 63); RedirectPC = RV + (tmp << 2); end
      endcase
      @(negedge clk);
      if (InstrValid) begin
        exp_w = mem_word(exp_pc);
        checks++; if (PC !== exp_pc) begin errors++;
          $display("FAIL rnd_pc cycle %0d got %h want %h", c, PC, exp_pc); end
        checks++; if (Instruction !== exp_w) begin errors++;
          $display("FAIL rnd_instr cycle %0d got %h want %h", c, Instruction, exp_w); end
        checks++; if (OP !== exp_w[31:26]) begin errors++;
          $display("FAIL rnd_op cycle %0d got %h want %h", c, OP, exp_w[31:26]); end
        checks++; if (PC_4 !== exp_pc + 32'd4) begin errors++;
          $display("FAIL rnd_pc4 cycle %0d got %h want %h", c, PC_4, exp_pc + 32'd4); end
      end
      if (IMemReq) begin
        checks++; if (IMemAddr[1:0] !== 2'b00) begin errors++;
          $display("FAIL rnd_align cycle %0d got %h want low bits 00", c, IMemAddr); end
      end
      if (prev_req && !prev_ack && !prev_redir) begin
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== prev_addr) begin errors++;
          $display("FAIL rnd_req_hold cycle %0d got %b/%h want 1/%h", c, IMemReq, IMemAddr,
                   prev_addr);
        end
      end
      if (Redirect) exp_pc = RedirectPC & 32'hFFFF_FFFC;
      else if (InstrValid && !Stall) begin
        exp_pc = exp_pc + 32'd4;
        n_xfer++;
      end
      prev_req   = IMemReq;
      prev_ack   = IMemAck;
      prev_redir = Redirect;
      prev_addr  = IMemAddr;
      cyc();
    end
    Redirect = 1'b0;
    Stall    = 1'b0;
    checks++; if (n_xfer < 100) begin errors++;
      $display("FAIL rnd_progress got %0d transfers want at least 100", n_xfer); end
  endtask

  initial begin
    reset      = 1'b0;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_redirect_hold();
    test_reset_hold_wrap();
`ifdef FETCH_PREFETCH_EN
    test_prefetch();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the MIPS processor. It is the producer side of the opcode path: it keeps the fetch PC, reads 32-bit instruction words from instruction memory over a request/response handshake, and presents each word with its PC to decode, where `OP` drives the Control unit. It stalls on decode back-pressure and discards wrong-path fetches when execute redirects the PC on a taken branch or jump.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0040_0000: first fetch address after reset.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `IMemReq`  out  1  fetch request valid.
- `IMemAddr`  out  32  fetch address; bits [1:0] are always 0.
- `IMemAck`  in  1  memory accepted the request this cycle.
- `IMemRValid`  in  1  read data valid.
- `IMemRData`  in  32  instruction word.
- `Stall`  in  1  decode cannot accept this cycle.
- `Redirect`  in  1  single-cycle pulse from execute for a taken branch or jump.
- `RedirectPC`  in  32  new fetch address; bits [1:0] are ignored and treated as 00.
- `Instruction`  out  32  instruction presented to decode.
- `OP`  out  6  `Instruction[31:26]`.
- `InstrValid`  out  1  `Instruction`, `PC` and `PC_4` are valid.
- `PC`  out  32  address of `Instruction`.
- `PC_4`  out  32  `PC + 4`, wrapping modulo 2^32.

## Operation
- Transfer to decode happens on any cycle with `InstrValid=1 && Stall=0`.
- Memory protocol:
  - `IMemReq` and `IMemAddr` are held until `IMemAck`.
  - The response arrives at least 1 cycle after ack.
  - Responses return in order, with at most one outstanding.
- Internal `fetch_pc` increments by 4 per accepted word and wraps modulo 2^32.
- FSM states: FETCH, WAIT, HOLD, DROP.
  - FETCH: `IMemReq=1`, `IMemAddr=fetch_pc`.
    - `IMemAck` → WAIT.
    - `Redirect` without ack: `fetch_pc←RedirectPC`, stay in FETCH. The address may change before ack only on a redirect.
    - `Redirect` and `IMemAck` in the same cycle: `fetch_pc←RedirectPC`, → DROP.
  - WAIT:
    - `IMemRValid`: `Instruction←IMemRData`, `PC←fetch_pc`, `InstrValid←1`, `fetch_pc←fetch_pc+4`, → HOLD.
    - `Redirect` without `IMemRValid`: `fetch_pc←RedirectPC`, → DROP.
    - `Redirect` and `IMemRValid` in the same cycle: discard the data, `fetch_pc←RedirectPC`, → FETCH.
  - HOLD: outputs are stable.
    - `Stall=0`: `InstrValid←0`, → FETCH.
    - `Redirect`: `InstrValid←0`, `fetch_pc←RedirectPC`, → FETCH. Redirect wins over a simultaneous transfer.
  - DROP: wait for `IMemRValid`, discard the data, → FETCH. A further `Redirect` in DROP only updates `fetch_pc`.
- Reset values while `reset=0`:
  - `IMemReq`, `IMemAddr`, `Instruction`, `OP`, `InstrValid`, `PC` = 0; `PC_4` = 4.
  - `fetch_pc=RESET_VECTOR`; state = FETCH.
  - `IMemReq` is gated low during reset.
  - Instruction memory shares the same reset, so no response crosses reset.

## Timing
- From `IMemAck` in cycle N with `IMemRValid` in cycle N+k: `InstrValid` rises at cycle N+k+1.
- Throughput with 1-cycle memory and `Stall=0`: one instruction per 3 cycles without prefetch, one per 2 cycles with prefetch.
- `Redirect` takes effect on the next edge. No wrong-path instruction reaches `InstrValid` after the redirect cycle.
- `OP` and `PC_4` are registered together with `Instruction` and `PC`; none of the outputs are combinational from inputs, except `IMemReq` reset gating.

## Configuration
- `FETCH_PREFETCH_EN` defined:
  - In HOLD, the unit also requests `fetch_pc` (the next sequential address).
  - A response received while HOLD persists goes into a one-entry prefetch buffer.
  - No request is issued while the buffer is full.
  - On transfer with the buffer full: the buffer moves to the outputs at the next edge, `InstrValid` stays 1, and the buffer empties.
  - `Redirect` empties the buffer and marks any outstanding response for DROP.
- Undefined:
  - No request is issued in HOLD.
  - The buffer logic is absent.

## Test plan
- Reset release with default vector, 1-cycle memory returning 32'h2008_0005, `Stall=0` → `IMemAddr`=0x0040_0000 in cycle 0; `InstrValid=1` in cycle 2 with `OP`=6'h08, `PC`=0x0040_0000, `PC_4`=0x0040_0004.
- `Stall=1` for 5 cycles in HOLD → `Instruction`/`PC` stable, exactly one transfer when `Stall` drops; next `IMemAddr`=0x0040_0004; without prefetch, `IMemReq`=0 throughout the stall.
- `Redirect` with `RedirectPC`=0x0040_0103 during WAIT → late response discarded, `InstrValid` stays 0, next `IMemAddr`=0x0040_0100.
- `Redirect` in the same cycle as `IMemRValid`, and separately in the same cycle as transfer in HOLD → no instruction from the old path appears; next fetch is at `RedirectPC`.
- `reset`=0 while in HOLD with `InstrValid=1` → next edge all outputs at reset values; after release, fetch restarts at `RESET_VECTOR`; `fetch_pc` 0xFFFF_FFFC wraps to 0x0000_0000.
- `FETCH_PREFETCH_EN`, 1-cycle memory, `Stall=1` for 4 cycles → exactly one prefetch request issued; on release, the second instruction follows with no `InstrValid` bubble, `PC`=first+4.
